execute_flag_write_sequencer: RTL and testbench
===============================================

# execute_flag_write_sequencer

Sequences flag-writing instructions between the issue stage and the execute flag register. It records which functional unit (shift, adder, mul, logic) owns the pending flag result and stalls issue while that result is outstanding. When the owning unit's result arrives, it emits exactly one registered flag-commit strobe. Results from the wrong unit, flushed results and lost results (timeout) are never committed.

## Interface
- P_TIMEOUT, 16: maximum WAIT cycles (non-held) before the pending flag write is abandoned; legal range 2..255.
- iCLOCK  input  1  clock; all state updates on the rising edge.
- iRESET_SYNC  input  1  reset, synchronous and active-high.
- iCTRL_HOLD  input  1  freeze all state, counter and outputs; no issue accepted.
- iFLUSH  input  1  cancel any pending flag write.
- iISSUE_VALID  input  1  instruction offered by issue stage.
- iISSUE_FLAG_WRITE  input  1  offered instruction writes flags.
- iISSUE_UNIT  input  2  owning unit: 0 shift, 1 adder, 2 mul, 3 logic.
- oISSUE_BUSY  output  1  issue stall; high in WAIT.
- iSHIFT_VALID / iADDER_VALID / iMUL_VALID / iLOGIC_VALID  input  1 each  unit result valid.
- iSHIFT_FLAG / iADDER_FLAG / iMUL_FLAG / iLOGIC_FLAG  input  5 each  unit flag result.
- oFLAG_WRITE_VALID  output  1  one-cycle commit strobe.
- oFLAG_WRITE_DATA  output  5  flags to commit.
- oFLAG_WRITE_UNIT  output  2  unit that produced the committed flags.
- oPENDING_UNIT  output  2  unit currently owed; 0 in IDLE.
- oTIMEOUT  output  1  one-cycle pulse when a pending write is abandoned.

## Operation
- States: IDLE, WAIT.
- Accept condition: iISSUE_VALID & !oISSUE_BUSY & !iCTRL_HOLD & !iFLUSH.
- Accept with iISSUE_FLAG_WRITE=1: latch iISSUE_UNIT into the pending register, clear the wait counter, go to WAIT.
- Accept with iISSUE_FLAG_WRITE=0: no state change.
- Issue offered while busy is ignored; the requester holds it until accepted.
- Match in WAIT (not held, not flushed): the VALID of the pending unit is high.
  - Next cycle: oFLAG_WRITE_VALID=1, oFLAG_WRITE_DATA = that unit's FLAG sampled at the match edge, oFLAG_WRITE_UNIT = pending unit, state IDLE.
- VALIDs of non-pending units are ignored in all states. All VALIDs are ignored in IDLE.
- Wait counter: 8-bit. Increments each non-held WAIT cycle without a match.
  - If the counter equals P_TIMEOUT-1 and there is no match, then next cycle: oTIMEOUT=1, state IDLE, no commit.
  - A match on the expiry cycle wins; no timeout.
- iFLUSH, when not held: next state IDLE, counter cleared, no commit, no timeout. Flush beats a same-cycle match or expiry.
- iCTRL_HOLD: highest priority below reset. State, counter and pending unit are frozen. oFLAG_WRITE_VALID and oTIMEOUT are forced low during hold, so a strobe is never duplicated. Matches during hold are not sampled.
- Priority: iRESET_SYNC > iCTRL_HOLD > iFLUSH > match > timeout.

## Timing
- Reset values: state IDLE, counter 0, oISSUE_BUSY 0, oFLAG_WRITE_VALID 0, oFLAG_WRITE_DATA 5'h00, oFLAG_WRITE_UNIT 0, oPENDING_UNIT 0, oTIMEOUT 0.
- Reset mid-WAIT discards the pending write with no strobe.
- oISSUE_BUSY is decoded from the state register; it rises the cycle after a flag-writing accept.
- Minimum latency: accept at edge N, match sampled at edge N+1, strobe during cycle N+1 to N+2.
- oISSUE_BUSY is low in the strobe cycle, so back-to-back flag writes sustain one commit every 2 cycles.
- oFLAG_WRITE_VALID and oTIMEOUT are registered single-cycle pulses and are mutually exclusive.

## Test plan
- Reset, then issue adder (unit 1, flag write); assert iADDER_VALID with flags 5'h13 one cycle later -> strobe with data 5'h13, unit 1, busy high for exactly 1 cycle.
- Issue mul (unit 2); pulse iSHIFT_VALID with 5'h1F at WAIT cycle 1; iMUL_VALID with 5'h04 at WAIT cycle 5 -> a single strobe with 5'h04, unit 2; the shift result is never committed.
- P_TIMEOUT=4: issue logic unit, no valid for 4 cycles -> oTIMEOUT pulse, no strobe, busy drops, next issue accepted. Repeat with iLOGIC_VALID on the expiry cycle -> strobe, no oTIMEOUT.
- Issue mul, then assert iFLUSH in the same cycle as iMUL_VALID -> no strobe, state IDLE next cycle.
- Issue shift, hold iCTRL_HOLD for 3 cycles while iSHIFT_VALID is high, then release -> no strobe during hold, one strobe after release, counter unchanged across hold.
- Issue with iISSUE_FLAG_WRITE=0 while iADDER_VALID=1 -> busy stays 0, no strobe; then assert iRESET_SYNC mid-WAIT -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/execute_flag_write_sequencer.sv
// Flag-write sequencer between issue and the execute flag register.
// A flag-writing instruction records its owning unit and stalls issue
// until that unit delivers a result, which is committed as a single
// registered strobe. Flushes and timeouts abandon the pending write.
module execute_flag_write_sequencer #(
  parameter int P_TIMEOUT = 16
) (
  input  logic       iCLOCK,
  input  logic       iRESET_SYNC,
  input  logic       iCTRL_HOLD,
  input  logic       iFLUSH,
  input  logic       iISSUE_VALID,
  input  logic       iISSUE_FLAG_WRITE,
  input  logic [1:0] iISSUE_UNIT,
  output logic       oISSUE_BUSY,
  input  logic       iSHIFT_VALID,
  input  logic       iADDER_VALID,
  input  logic       iMUL_VALID,
  input  logic       iLOGIC_VALID,
  input  logic [4:0] iSHIFT_FLAG,
  input  logic [4:0] iADDER_FLAG,
  input  logic [4:0] iMUL_FLAG,
  input  logic [4:0] iLOGIC_FLAG,
  output logic       oFLAG_WRITE_VALID,
  output logic [4:0] oFLAG_WRITE_DATA,
  output logic [1:0] oFLAG_WRITE_UNIT,
  output logic [1:0] oPENDING_UNIT,
  output logic       oTIMEOUT
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(P_TIMEOUT - 1);

  state_t     state;
  logic [7:0] waitCnt;
  logic [1:0] pendingUnit;
  logic       commitVld_p1;
  logic [4:0] commitData_p1;
  logic [1:0] commitUnit_p1;
  logic       timeout_p1;

  logic       matchVld_p0;
  logic [4:0] matchFlag_p0;
  logic       accept;

  // Select the valid/flag pair of the unit currently owed a result.
  always_comb begin
    matchVld_p0  = 1'b0;
    matchFlag_p0 = 5'h00;
    case (pendingUnit)
      2'd0: begin matchVld_p0 = iSHIFT_VALID; matchFlag_p0 = iSHIFT_FLAG; end
      2'd1: begin matchVld_p0 = iADDER_VALID; matchFlag_p0 = iADDER_FLAG; end
      2'd2: begin matchVld_p0 = iMUL_VALID;   matchFlag_p0 = iMUL_FLAG;   end
      default: begin matchVld_p0 = iLOGIC_VALID; matchFlag_p0 = iLOGIC_FLAG; end
    endcase
  end

  assign oISSUE_BUSY   = (state == WAIT);
  assign oPENDING_UNIT = (state == WAIT) ? pendingUnit : 2'd0;
  assign accept        = iISSUE_VALID & ~oISSUE_BUSY & ~iCTRL_HOLD & ~iFLUSH;

  // Sequencer state, wait counter and registered commit/timeout pulses.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state         <= IDLE;
      waitCnt       <= 8'd0;
      pendingUnit   <= 2'd0;
      commitVld_p1  <= 1'b0;
      commitData_p1 <= 5'h00;
      commitUnit_p1 <= 2'd0;
      timeout_p1    <= 1'b0;
    end else if (iCTRL_HOLD) begin
      // Frozen; pulses drop so a strobe is never repeated across a hold.
      commitVld_p1 <= 1'b0;
      timeout_p1   <= 1'b0;
    end else begin
      commitVld_p1 <= 1'b0;
      timeout_p1   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && iISSUE_FLAG_WRITE) begin
            pendingUnit <= iISSUE_UNIT;
            waitCnt     <= 8'd0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (iFLUSH) begin
            waitCnt <= 8'd0;
            state   <= IDLE;
          end else if (matchVld_p0) begin
            commitVld_p1  <= 1'b1;
            commitData_p1 <= matchFlag_p0;
            commitUnit_p1 <= pendingUnit;
            waitCnt       <= 8'd0;
            state         <= IDLE;
          end else if (waitCnt == LAST_WAIT) begin
            timeout_p1 <= 1'b1;
            waitCnt    <= 8'd0;
            state      <= IDLE;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: registered commit outputs ----
  assign oFLAG_WRITE_VALID = commitVld_p1;
  assign oFLAG_WRITE_DATA  = commitData_p1;
  assign oFLAG_WRITE_UNIT  = commitUnit_p1;
  assign oTIMEOUT          = timeout_p1;

endmodule

// File: tb/tb_execute_flag_write_sequencer.sv
// Bench for execute_flag_write_sequencer: directed scenarios and random
// traffic, every cycle compared against a behavioural model.
module tb_execute_flag_write_sequencer;

  localparam int TMO = 4;

  logic       iCLOCK = 1'b0;
  logic       iRESET_SYNC, iCTRL_HOLD, iFLUSH;
  logic       iISSUE_VALID, iISSUE_FLAG_WRITE;
  logic [1:0] iISSUE_UNIT;
  logic       oISSUE_BUSY;
  logic       iSHIFT_VALID, iADDER_VALID, iMUL_VALID, iLOGIC_VALID;
  logic [4:0] iSHIFT_FLAG, iADDER_FLAG, iMUL_FLAG, iLOGIC_FLAG;
  logic       oFLAG_WRITE_VALID;
  logic [4:0] oFLAG_WRITE_DATA;
  logic [1:0] oFLAG_WRITE_UNIT;
  logic [1:0] oPENDING_UNIT;
  logic       oTIMEOUT;

  int checks = 0;
  int errors = 0;

  // Model: owed = -1 when nothing is pending, otherwise the unit owed.
  int         owed = -1;
  int         age  = 0;
  logic       expV = 1'b0;
  logic       expT = 1'b0;
  logic [4:0] expD = 5'h00;
  logic [1:0] expU = 2'd0;

  execute_flag_write_sequencer #(.P_TIMEOUT(TMO)) dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .iCTRL_HOLD(iCTRL_HOLD),
    .iFLUSH(iFLUSH), .iISSUE_VALID(iISSUE_VALID),
    .iISSUE_FLAG_WRITE(iISSUE_FLAG_WRITE), .iISSUE_UNIT(iISSUE_UNIT),
    .oISSUE_BUSY(oISSUE_BUSY),
    .iSHIFT_VALID(iSHIFT_VALID), .iADDER_VALID(iADDER_VALID),
    .iMUL_VALID(iMUL_VALID), .iLOGIC_VALID(iLOGIC_VALID),
    .iSHIFT_FLAG(iSHIFT_FLAG), .iADDER_FLAG(iADDER_FLAG),
    .iMUL_FLAG(iMUL_FLAG), .iLOGIC_FLAG(iLOGIC_FLAG),
    .oFLAG_WRITE_VALID(oFLAG_WRITE_VALID), .oFLAG_WRITE_DATA(oFLAG_WRITE_DATA),
    .oFLAG_WRITE_UNIT(oFLAG_WRITE_UNIT), .oPENDING_UNIT(oPENDING_UNIT),
    .oTIMEOUT(oTIMEOUT)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the sequencer's rules to the inputs presented before the next edge.
  task automatic modelStep();
    logic       uv[4];
    logic [4:0] uf[4];
    uv[0] = iSHIFT_VALID; uv[1] = iADDER_VALID; uv[2] = iMUL_VALID; uv[3] = iLOGIC_VALID;
    uf[0] = iSHIFT_FLAG;  uf[1] = iADDER_FLAG;  uf[2] = iMUL_FLAG;  uf[3] = iLOGIC_FLAG;
    if (iRESET_SYNC) begin
      owed = -1; age = 0; expV = 0; expT = 0; expD = 5'h00; expU = 2'd0;
    end else if (iCTRL_HOLD) begin
      expV = 0; expT = 0;
    end else begin
      expV = 0; expT = 0;
      if (owed < 0) begin
        if (iISSUE_VALID && iISSUE_FLAG_WRITE && !iFLUSH) begin
          owed = int'(iISSUE_UNIT); age = 0;
        end
      end else if (iFLUSH) begin
        owed = -1; age = 0;
      end else if (uv[owed]) begin
        expV = 1; expD = uf[owed]; expU = 2'(owed); owed = -1; age = 0;
      end else if (age + 1 == TMO) begin
        expT = 1; owed = -1; age = 0;
      end else begin
        age++;
      end
    end
  endtask

  task automatic checkAll();
    chk("busy",    8'(oISSUE_BUSY),       8'(owed >= 0));
    chk("pending", 8'(oPENDING_UNIT),     (owed >= 0) ? 8'(owed) : 8'd0);
    chk("fwValid", 8'(oFLAG_WRITE_VALID), 8'(expV));
    chk("fwData",  8'(oFLAG_WRITE_DATA),  8'(expD));
    chk("fwUnit",  8'(oFLAG_WRITE_UNIT),  8'(expU));
    chk("timeout", 8'(oTIMEOUT),          8'(expT));
  endtask

  // One clock: predict, advance, then compare just after the edge.
  task automatic cycle();
    modelStep();
    @(posedge iCLOCK);
    #1;
    checkAll();
  endtask

  task automatic quiet();
    iRESET_SYNC = 0; iCTRL_HOLD = 0; iFLUSH = 0;
    iISSUE_VALID = 0; iISSUE_FLAG_WRITE = 0; iISSUE_UNIT = 2'd0;
    iSHIFT_VALID = 0; iADDER_VALID = 0; iMUL_VALID = 0; iLOGIC_VALID = 0;
    iSHIFT_FLAG = 5'h00; iADDER_FLAG = 5'h00; iMUL_FLAG = 5'h00; iLOGIC_FLAG = 5'h00;
  endtask

  task automatic issue(input logic [1:0] unit, input logic fw);
    iISSUE_VALID = 1; iISSUE_FLAG_WRITE = fw; iISSUE_UNIT = unit;
    cycle();
    iISSUE_VALID = 0; iISSUE_FLAG_WRITE = 0;
  endtask

  initial begin
    quiet();
    iRESET_SYNC = 1;
    cycle(); cycle();
    iRESET_SYNC = 0;
    chk("rstBusy", 8'(oISSUE_BUSY), 8'd0);
    chk("rstValid", 8'(oFLAG_WRITE_VALID), 8'd0);

    // Adder result one cycle after issue.
    issue(2'd1, 1'b1);
    chk("adderBusy", 8'(oISSUE_BUSY), 8'd1);
    iADDER_VALID = 1; iADDER_FLAG = 5'h13;
    cycle();
    quiet();
    chk("adderStrobe", 8'(oFLAG_WRITE_VALID), 8'd1);
    chk("adderData", 8'(oFLAG_WRITE_DATA), 8'h13);
    chk("adderBusyLow", 8'(oISSUE_BUSY), 8'd0);

    // Mul owed, shift result ignored; TMO=4 would expire, so mul arrives on cycle 3.
    issue(2'd2, 1'b1);
    iSHIFT_VALID = 1; iSHIFT_FLAG = 5'h1F; cycle(); quiet();
    cycle();
    iMUL_VALID = 1; iMUL_FLAG = 5'h04; cycle(); quiet();
    chk("mulData", 8'(oFLAG_WRITE_DATA), 8'h04);
    chk("mulUnit", 8'(oFLAG_WRITE_UNIT), 8'd2);

    // Logic timeout, then match on the expiry cycle.
    issue(2'd3, 1'b1);
    repeat (TMO) cycle();
    chk("tmoPulse", 8'(oTIMEOUT), 8'd1);
    issue(2'd3, 1'b1);
    repeat (TMO - 1) cycle();
    iLOGIC_VALID = 1; iLOGIC_FLAG = 5'h0A; cycle(); quiet();
    chk("expiryMatch", 8'(oFLAG_WRITE_VALID), 8'd1);
    chk("expiryNoTmo", 8'(oTIMEOUT), 8'd0);

    // Flush beats a same-cycle match.
    issue(2'd2, 1'b1);
    iFLUSH = 1; iMUL_VALID = 1; iMUL_FLAG = 5'h07; cycle(); quiet();
    chk("flushNoStrobe", 8'(oFLAG_WRITE_VALID), 8'd0);

    // Hold with a valid shift result, then release.
    issue(2'd0, 1'b1);
    iSHIFT_VALID = 1; iSHIFT_FLAG = 5'h15; iCTRL_HOLD = 1;
    repeat (3) cycle();
    iCTRL_HOLD = 0; cycle(); quiet();
    chk("holdRelease", 8'(oFLAG_WRITE_VALID), 8'd1);
    cycle();

    // Non-flag issue, then reset in the middle of WAIT.
    iADDER_VALID = 1; iADDER_FLAG = 5'h11;
    issue(2'd1, 1'b0);
    quiet();
    issue(2'd1, 1'b1);
    iRESET_SYNC = 1; cycle(); quiet();
    cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      iRESET_SYNC       = ($urandom_range(0, 63) == 0);
      iCTRL_HOLD        = ($urandom_range(0, 5) == 0);
      iFLUSH            = ($urandom_range(0, 15) == 0);
      iISSUE_VALID      = $urandom_range(0, 1) == 1;
      iISSUE_FLAG_WRITE = ($urandom_range(0, 3) != 0);
      iISSUE_UNIT       = 2'($urandom_range(0, 3));
      iSHIFT_VALID      = ($urandom_range(0, 4) == 0);
      iADDER_VALID      = ($urandom_range(0, 4) == 0);
      iMUL_VALID        = ($urandom_range(0, 4) == 0);
      iLOGIC_VALID      = ($urandom_range(0, 4) == 0);
      iSHIFT_FLAG       = 5'($urandom);
      iADDER_FLAG       = 5'($urandom);
      iMUL_FLAG         = 5'($urandom);
      iLOGIC_FLAG       = 5'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
